reveal_fsm: RTL and testbench
=============================

# reveal_fsm

Consumes the packed adjacency-count vector and done flag produced by the board-setup stage, plus the 64-bit mine map, and turns player clicks into revealed-tile state for an 8x8 board. Flood-fills zero-count regions by repeated raster sweeps, one tile per cycle. Flags loss on a mine hit and a win once every non-mine tile is revealed. Sits between the setup stage and the display/input logic.

## Interface
- No parameters. Board fixed at 8x8, 64 tiles, tile index = row*8 + col, row = index[5:3], col = index[2:0].
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- adj  input  256  tile t count in adj[4t+3:4t], range 0..8.
- adj_done  input  1  high once adj is valid; adj and mine_map stable thereafter.
- mine_map  input  64  bit t = 1: tile t holds a mine.
- click_valid  input  1  click request.
- click_index  input  6  clicked tile.
- click_ready  output  1  high only in READY; click accepted when click_valid & click_ready at a rising edge.
- revealed  output  64  bit t = 1: tile t revealed.
- reveal_count  output  7  number of set bits in revealed, 0..64.
- busy  output  1  high in PROBE, SWEEP, EVAL.
- lost  output  1  sticky; mine revealed.
- won  output  1  sticky; all non-mine tiles revealed.

## Operation
- States: IDLE, READY, PROBE, SWEEP, EVAL, LOST, WON. All outputs are registered.
- IDLE: wait for adj_done = 1, then go to READY. adj_done is sampled only in IDLE. Clicks are ignored in IDLE.
- READY: click_ready = 1. On acceptance, latch click_index into tgt and go to PROBE.
- PROBE, three cases:
  - revealed[tgt] already set: no change; go to EVAL.
  - mine_map[tgt] = 1: set revealed[tgt], increment reveal_count, set lost; go to LOST.
  - otherwise: set revealed[tgt] and increment reveal_count. If adj count of tgt = 0, clear idx and changed and go to SWEEP; else go to EVAL.
- SWEEP (one tile idx per cycle):
  - Tile idx is revealed this cycle if it is not revealed, not a mine, and has at least one in-board 8-neighbour that is revealed with count 0.
  - Revealing sets the bit, increments reveal_count and sets changed.
  - Neighbours have no wrap-around: col 0 has no left neighbours, col 7 no right, row 0 none above, row 7 none below.
  - Neighbour evaluation uses the registered revealed vector, so reveals at lower idx earlier in the same pass are visible.
  - At idx = 63: if changed (including a reveal of 63 itself in that cycle), set idx = 0, clear changed and stay in SWEEP; else go to EVAL.
- EVAL: if (revealed | mine_map) is all ones, set won and go to WON; else go to READY.
- LOST and WON are terminal until reset. click_ready = 0 and revealed is frozen in both.
- Reset at any time, including mid-sweep: return to IDLE and restore all reset values.

## Timing
- Reset values: click_ready = 0, revealed = 0, reveal_count = 0, busy = 0, lost = 0, won = 0; internal idx = 0, changed = 0, tgt = 0.
- Cycles are counted from the acceptance edge as cycle 0.
- PROBE occupies cycle 1.
- Non-zero, already-revealed or mine click:
  - EVAL or LOST in cycle 2.
  - click_ready high again in cycle 3 (non-LOST, non-WON).
  - lost visible in cycle 2.
- Zero-count click with P sweep passes (P >= 1, the last pass makes no change):
  - SWEEP occupies cycles 2 .. 1+64P.
  - EVAL in cycle 2+64P.
  - READY or WON in cycle 3+64P.
- won is visible in the cycle after EVAL.
- revealed and reveal_count change exactly one cycle after the deciding PROBE or SWEEP cycle, and always agree.
- IDLE to READY takes one cycle after adj_done is first sampled high.

## Test plan
- Click before adj_done: mine_map = 0, click_valid held high with index 5 while adj_done = 0 for 10 cycles -> click_ready = 0, revealed = 0 throughout. Then raise adj_done -> READY and click accepted.
- Mine hit: mine_map = 1<<27, adj consistent, click 27 -> cycle 2 lost = 1, revealed = 1<<27, reveal_count = 1; click_ready stays 0 over 20 further cycles.
- Numbered tile: mine at 0, click 9 (count 1) -> revealed = 1<<9, reveal_count = 1, click_ready high in cycle 3. Re-click 9 -> no change, ready again in cycle 3.
- Empty board: mine_map = 0, adj = 0, click 0 -> pass 1 reveals tiles 1..63, pass 2 makes no change. EVAL at cycle 130, won = 1, revealed = all ones, reveal_count = 64.
- Backward propagation: mine_map = 0, adj = 0, click 63 -> more than 2 passes. Final revealed = all ones and won = 1, with pass count and per-cycle reveal order matching a raster-sweep reference model.
- Reset mid-sweep: assert rst low during pass 1 of the empty-board case -> all outputs return to reset values immediately. After release with adj_done high -> READY after one cycle, revealed = 0.

Source files
------------

// File: rtl/reveal_fsm.sv
// reveal_fsm
// Turns player clicks into revealed-tile state for an 8x8 minesweeper board.
// A click on a zero-count tile starts a flood fill. The flood fill makes repeated
// raster sweeps over all 64 tiles, one tile per cycle, until a full pass reveals
// nothing new. A mine hit sets the sticky lost flag. The sticky won flag is set
// once every non-mine tile is revealed.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   adj          packed adjacency counts; tile t in adj[4t+3:4t]
//   adj_done     adj/mine_map valid (sampled only while idle)
//   mine_map     bit t set: tile t holds a mine
//   click_valid  click request
//   click_index  clicked tile, row*8 + col
//   click_ready  high while waiting for a click
//   revealed     bit t set: tile t revealed
//   reveal_count number of set bits in revealed
//   busy         evaluating a click
//   lost         sticky, a mine was revealed
//   won          sticky, all non-mine tiles revealed
module reveal_fsm (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] adj,
  input  logic         adj_done,
  input  logic [63:0]  mine_map,
  input  logic         click_valid,
  input  logic [5:0]   click_index,
  output logic         click_ready,
  output logic [63:0]  revealed,
  output logic [6:0]   reveal_count,
  output logic         busy,
  output logic         lost,
  output logic         won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_PROBE,
    S_SWEEP,
    S_EVAL,
    S_LOST,
    S_WON
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] revealed_q, revealed_d;
  logic [6:0]  count_q, count_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  tgt_q, tgt_d;
  logic        changed_q, changed_d;
  logic        lost_q, lost_d;
  logic        won_q, won_d;
  logic        click_ready_q, click_ready_d;
  logic        busy_q, busy_d;
  logic        sweep_hit;

  function automatic logic [3:0] tile_cnt(input logic [255:0] a, input logic [5:0] t);
    return a[{t, 2'b00} +: 4];
  endfunction

  // True when some in-board 8-neighbour of t is revealed and has count 0.
  // Rows and columns are bounds-checked, so no neighbour wraps around an edge.
  function automatic logic zero_nbr(input logic [63:0] rev, input logic [255:0] a,
                                    input logic [5:0] t);
    int         rr;
    int         cc;
    logic [5:0] j;
    logic       hit;
    hit = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = int'(t[5:3]) + dr;
        cc = int'(t[2:0]) + dc;
        j  = 6'((rr * 8) + cc);
        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
          if (rev[j] && tile_cnt(a, j) == 4'd0) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      revealed_q    <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      tgt_q         <= '0;
      changed_q     <= 1'b0;
      lost_q        <= 1'b0;
      won_q         <= 1'b0;
      click_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      revealed_q    <= revealed_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      tgt_q         <= tgt_d;
      changed_q     <= changed_d;
      lost_q        <= lost_d;
      won_q         <= won_d;
      click_ready_q <= click_ready_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    count_d    = count_q;
    idx_d      = idx_q;
    tgt_d      = tgt_q;
    changed_d  = changed_q;
    lost_d     = lost_q;
    won_d      = won_q;
    sweep_hit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (adj_done) state_d = S_READY;
      end
      S_READY: begin
        if (click_valid) begin
          tgt_d   = click_index;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (revealed_q[tgt_q]) begin
          state_d = S_EVAL;
        end else begin
          revealed_d[tgt_q] = 1'b1;
          count_d           = count_q + 7'd1;
          if (mine_map[tgt_q]) begin
            lost_d  = 1'b1;
            state_d = S_LOST;
          end else if (tile_cnt(adj, tgt_q) == 4'd0) begin
            idx_d     = '0;
            changed_d = 1'b0;
            state_d   = S_SWEEP;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_SWEEP: begin
        // Neighbour test reads revealed_q, so reveals earlier in this pass count.
        sweep_hit = !revealed_q[idx_q] && !mine_map[idx_q] &&
                    zero_nbr(revealed_q, adj, idx_q);
        if (sweep_hit) begin
          revealed_d[idx_q] = 1'b1;
          count_d           = count_q + 7'd1;
          changed_d         = 1'b1;
        end
        if (idx_q == 6'd63) begin
          // A pass that revealed anything (including tile 63 now) forces another pass.
          if (changed_q || sweep_hit) begin
            idx_d     = '0;
            changed_d = 1'b0;
          end else begin
            state_d = S_EVAL;
          end
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_EVAL: begin
        if (&(revealed_q | mine_map)) begin
          won_d   = 1'b1;
          state_d = S_WON;
        end else begin
          state_d = S_READY;
        end
      end
      default: begin
        // S_LOST and S_WON are terminal until reset.
      end
    endcase

    click_ready_d = (state_d == S_READY);
    busy_d        = (state_d == S_PROBE) || (state_d == S_SWEEP) || (state_d == S_EVAL);
  end

  assign click_ready  = click_ready_q;
  assign revealed     = revealed_q;
  assign reveal_count = count_q;
  assign busy         = busy_q;
  assign lost         = lost_q;
  assign won          = won_q;

endmodule

// File: tb/tb_reveal_fsm.sv
// Bench for reveal_fsm: directed clicks against a board-level model that
// predicts, per cycle, the mode (idle/ready/busy/lost/won) and revealed set.
module tb_reveal_fsm;

  localparam int M_IDLE  = 0;
  localparam int M_READY = 1;
  localparam int M_BUSY  = 2;
  localparam int M_LOST  = 3;
  localparam int M_WON   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [255:0] adj = '0;
  logic         adj_done = 1'b0;
  logic [63:0]  mine_map = '0;
  logic         click_valid = 1'b0;
  logic [5:0]   click_index = '0;
  logic         click_ready;
  logic [63:0]  revealed;
  logic [6:0]   reveal_count;
  logic         busy;
  logic         lost;
  logic         won;

  reveal_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .adj         (adj),
    .adj_done    (adj_done),
    .mine_map    (mine_map),
    .click_valid (click_valid),
    .click_index (click_index),
    .click_ready (click_ready),
    .revealed    (revealed),
    .reveal_count(reveal_count),
    .busy        (busy),
    .lost        (lost),
    .won         (won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    logic [63:0] rev;
  } ent_t;

  ent_t        q[$];
  int          exp_mode = M_IDLE;
  logic [63:0] exp_rev = '0;
  int          checks = 0;
  int          errors = 0;
  int          last_passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("click_ready", 64'(click_ready), 64'(exp_mode == M_READY));
    chk("busy", 64'(busy), 64'(exp_mode == M_BUSY));
    chk("lost", 64'(lost), 64'(exp_mode == M_LOST));
    chk("won", 64'(won), 64'(exp_mode == M_WON));
    chk("revealed", revealed, exp_rev);
    chk("reveal_count", 64'(reveal_count), 64'($countones(exp_rev)));
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int cnt(input int j);
    return int'(adj[j*4 +: 4]);
  endfunction

  function automatic logic [255:0] mk_adj(input logic [63:0] m);
    logic [255:0] a;
    int n;
    a = '0;
    for (int t = 0; t < 64; t++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          int rr = t / 8 + dr;
          int cc = t % 8 + dc;
          if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
            if (m[rr*8+cc]) n++;
        end
      a[t*4 +: 4] = 4'(n);
    end
    return a;
  endfunction

  function automatic bit zero_nbr(input logic [63:0] r, input int i);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = i / 8 + dr;
        int cc = i % 8 + dc;
        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
          if (r[rr*8+cc] && cnt(rr*8+cc) == 0) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic push(input int m, input logic [63:0] r);
    ent_t e;
    e.mode = m;
    e.rev  = r;
    q.push_back(e);
  endtask

  task automatic push_final(input logic [63:0] r);
    if (&(r | mine_map)) push(M_WON, r);
    else push(M_READY, r);
  endtask

  // Expected outputs for cycles 1.. after an accepted click on tile t.
  task automatic plan_click(input int t);
    logic [63:0] r;
    bit ch;
    r = exp_rev;
    last_passes = 0;
    push(M_BUSY, r);
    if (r[t]) begin
      push(M_BUSY, r);
      push_final(r);
    end else if (mine_map[t]) begin
      r[t] = 1'b1;
      push(M_LOST, r);
    end else begin
      r[t] = 1'b1;
      if (cnt(t) != 0) begin
        push(M_BUSY, r);
        push_final(r);
      end else begin
        do begin
          ch = 1'b0;
          last_passes++;
          for (int i = 0; i < 64; i++) begin
            push(M_BUSY, r);
            if (!r[i] && !mine_map[i] && zero_nbr(r, i)) begin
              r[i] = 1'b1;
              ch = 1'b1;
            end
          end
        end while (ch);
        push(M_BUSY, r);
        push_final(r);
      end
    end
  endtask

  task automatic step();
    ent_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_mode = e.mode;
      exp_rev  = e.rev;
    end
  endtask

  task automatic click(input int t);
    click_valid = 1'b1;
    click_index = 6'(t);
    plan_click(t);
    step();
    click_valid = 1'b0;
  endtask

  task automatic run_out();
    while (q.size() > 0) step();
    step();
    step();
  endtask

  task automatic model_reset();
    q.delete();
    exp_mode = M_IDLE;
    exp_rev  = '0;
  endtask

  task automatic do_reset(input logic [63:0] mines);
    rst = 1'b0;
    adj_done = 1'b0;
    model_reset();
    mine_map = mines;
    adj = mk_adj(mines);
    step();
    step();
    rst = 1'b1;
    step();
    adj_done = 1'b1;
    push(M_READY, '0);
    step();
  endtask

  int c;

  initial begin
    // Clicks before adj_done are ignored.
    mine_map = '0;
    adj = '0;
    click_valid = 1'b1;
    click_index = 6'd5;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_ready_idle", 64'(click_ready), 64'd0);
      chk("t1_revealed_idle", revealed, 64'd0);
    end
    adj_done = 1'b1;
    push(M_READY, '0);
    step();
    chk("t1_ready", 64'(click_ready), 64'd1);
    click(5);
    run_out();
    chk("t1_won", 64'(won), 64'd1);

    // Mine hit.
    do_reset(64'd1 << 27);
    click(27);
    chk("t2_lost_c1", 64'(lost), 64'd0);
    step();
    chk("t2_lost_c2", 64'(lost), 64'd1);
    chk("t2_revealed_c2", revealed, 64'd1 << 27);
    chk("t2_count_c2", 64'(reveal_count), 64'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t2_ready_frozen", 64'(click_ready), 64'd0);
    end

    // Numbered tile, then re-click.
    do_reset(64'd1);
    click(9);
    step();
    chk("t3_ready_c2", 64'(click_ready), 64'd0);
    step();
    chk("t3_ready_c3", 64'(click_ready), 64'd1);
    chk("t3_revealed", revealed, 64'd1 << 9);
    chk("t3_count", 64'(reveal_count), 64'd1);
    click(9);
    step();
    step();
    chk("t3_reclick_ready_c3", 64'(click_ready), 64'd1);
    chk("t3_reclick_revealed", revealed, 64'd1 << 9);

    // Empty board, click 0: two passes, EVAL at 130, won at 131.
    do_reset('0);
    click(0);
    chk("t4_model_passes", 64'(last_passes), 64'd2);
    c = 1;
    while (!won && c < 400) begin
      step();
      c++;
    end
    chk("t4_won_cycle", 64'(c), 64'd131);
    chk("t4_revealed", revealed, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_count", 64'(reveal_count), 64'd64);
    run_out();

    // Backward propagation from the last tile.
    do_reset('0);
    click(63);
    chk("t5_model_passes_gt2", 64'(last_passes > 2), 64'd1);
    run_out();
    chk("t5_won", 64'(won), 64'd1);
    chk("t5_revealed", revealed, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset in the middle of pass 1.
    do_reset('0);
    click(0);
    for (int i = 0; i < 20; i++) step();
    chk("t6_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_revealed_rst", revealed, 64'd0);
    chk("t6_count_rst", 64'(reveal_count), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    step();
    step();
    rst = 1'b1;
    push(M_READY, '0);
    step();
    chk("t6_ready_after", 64'(click_ready), 64'd1);
    chk("t6_revealed_after", revealed, 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
